// File: rtl/ground_pkg.sv
// ============================================================================
// ground_pkg
// Shared geometry constants and coordinate type for the ground strip. Used
// by ground_scroller, ground_palette and the top-level colour mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ground_pkg;

  localparam int GROUND_W = 256;   // strip width in pixels, power of 2
  localparam int GROUND_H = 32;    // strip height in pixels
  localparam int GROUND_Y = 400;   // first screen row of the strip
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPEED_W  = 4;     // width of the per-frame scroll step

  typedef logic [9:0] pix_coord_t;

endpackage

`default_nettype wire

// File: rtl/ground_scroller_if.sv
// ============================================================================
// ground_scroller_if
// Pixel-stream bundle between the beam generator, the ground ROM and
// ground_scroller.
//   drawX/drawY/vde : beam position and display enable
//   rom_addr/rom_q  : synchronous ground ROM port (1-cycle read latency)
//   pix_index       : 4-bit colour index for ground_palette
//   pix_valid       : beam inside strip and display enabled
// master = ground_scroller side, slave = beam source / ROM / palette side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ground_scroller_if
  import ground_pkg::*;
#(
  parameter int ADDR_W = $clog2(GROUND_W * GROUND_H)
) ();

  pix_coord_t        drawX;
  pix_coord_t        drawY;
  logic              vde;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        pix_index;
  logic              pix_valid;

  modport master (
    input  drawX, drawY, vde, rom_q,
    output rom_addr, pix_index, pix_valid
  );

  modport slave (
    output drawX, drawY, vde, rom_q,
    input  rom_addr, pix_index, pix_valid
  );

endinterface

`default_nettype wire

// File: rtl/ground_scroller.sv
// ============================================================================
// ground_scroller
// Maps the VGA beam position into the horizontally scrolling ground strip,
// drives the ground ROM address and registers the returned colour index.
// The scroll offset advances once per frame on the vsync falling edge.
//   clk     : pixel clock
//   reset_n : asynchronous active-low reset
//   vsync   : VGA vsync, active low
//   run     : scroll enable
//   clear   : synchronous offset clear (beats a frame tick)
//   speed   : scroll step per frame, pixels
//   offset  : current scroll offset
//   bus     : beam inputs, ROM port and pixel outputs (master side)
// Pixel outputs lag the beam inputs by 3 clock edges.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ground_scroller
  import ground_pkg::*;
#(
  parameter int GROUND_W = ground_pkg::GROUND_W,
  parameter int GROUND_H = ground_pkg::GROUND_H,
  parameter int GROUND_Y = ground_pkg::GROUND_Y,
  parameter int SPEED_W  = ground_pkg::SPEED_W,
  parameter int ADDR_W   = $clog2(GROUND_W * GROUND_H)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        vsync,
  input  logic                        run,
  input  logic                        clear,
  input  logic [SPEED_W-1:0]          speed,
  output logic [$clog2(GROUND_W)-1:0] offset,
  ground_scroller_if.master           bus
);

  localparam int         COL_W     = $clog2(GROUND_W);
  localparam int         ROW_W     = ADDR_W - COL_W;
  localparam pix_coord_t C_BAND_LO = pix_coord_t'(GROUND_Y);
  localparam pix_coord_t C_BAND_HI = pix_coord_t'(GROUND_Y + GROUND_H);

  logic             r_vsync_q;
  logic             w_tick;
  logic [COL_W-1:0] r_offset;

  logic             w_in_band;
  logic [COL_W:0]   w_col_sum;
  logic [COL_W-1:0] w_col;
  pix_coord_t       w_row;
  logic             r_valid1;
  logic             r_valid2;
  logic             w_unused;

  // --------------------------------------------------------------------------
  // Frame tick and scroll offset. Speed is only looked at on the tick, so the
  // offset is constant for the whole visible frame.
  // --------------------------------------------------------------------------
  assign w_tick = r_vsync_q & ~vsync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_q <= 1'b1;
      r_offset  <= '0;
    end else begin
      r_vsync_q <= vsync;
      if (clear) begin
        r_offset <= '0;
      end else if (w_tick && run) begin
        r_offset <= r_offset + COL_W'(speed);   // wraps mod GROUND_W
      end
    end
  end

  assign offset = r_offset;

  // --------------------------------------------------------------------------
  // Stage 1 address generation. The column sum carries one extra bit that is
  // dropped, giving the horizontal wrap for free; the row multiply is just
  // the row bits concatenated above the column bits.
  // --------------------------------------------------------------------------
  assign w_in_band = bus.vde && (bus.drawY >= C_BAND_LO) && (bus.drawY < C_BAND_HI);
  assign w_col_sum = {1'b0, bus.drawX[COL_W-1:0]} + {1'b0, r_offset};
  assign w_col     = w_col_sum[COL_W-1:0];
  assign w_row     = bus.drawY - C_BAND_LO;

  // Upper beam/row bits and the column carry are deliberately discarded.
  assign w_unused  = ^{bus.drawX, w_col_sum, w_row};

  // --------------------------------------------------------------------------
  // Pipeline: stage 1 registers the address, stage 2 is the ROM's own
  // register (valid delayed here to match), stage 3 registers the index.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rom_addr  <= '0;
      r_valid1      <= 1'b0;
      r_valid2      <= 1'b0;
      bus.pix_index <= '0;
      bus.pix_valid <= 1'b0;
    end else begin
      if (w_in_band) begin
        bus.rom_addr <= {w_row[ROW_W-1:0], w_col};
      end
      r_valid1      <= w_in_band;
      r_valid2      <= r_valid1;
      bus.pix_index <= r_valid2 ? bus.rom_q : 4'd0;
      bus.pix_valid <= r_valid2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ground_scroller.sv
// ============================================================================
// tb_ground_scroller
// Self-checking bench for ground_scroller: directed scenarios with literal
// expectations plus randomized frames checked every cycle against a
// behavioural model of the strip mapping and scroll offset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ground_scroller;
  import ground_pkg::*;

  localparam int COL_W  = $clog2(GROUND_W);
  localparam int ADDR_W = $clog2(GROUND_W * GROUND_H);
  localparam int DEPTH  = GROUND_W * GROUND_H;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic             vsync   = 1'b1;
  logic             run     = 1'b0;
  logic             clear   = 1'b0;
  logic [3:0]       speed   = 4'd0;
  logic [COL_W-1:0] offset;

  ground_scroller_if #(.ADDR_W(ADDR_W)) bus ();

  ground_scroller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .run     (run),
    .clear   (clear),
    .speed   (speed),
    .offset  (offset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // External ground ROM: synchronous read, one cycle of latency.
  logic [3:0] rom [0:DEPTH-1];
  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: what each beam sample should become three edges later.
  // --------------------------------------------------------------------------
  int m_off, m_addr, m_vq;
  int h_band [3];
  int h_addr [3];
  int mx, my, ma, mb, exp_idx;

  function automatic void model_reset();
    m_off  = 0;
    m_addr = 0;
    m_vq   = 1;
    for (int i = 0; i < 3; i++) begin
      h_band[i] = 0;
      h_addr[i] = 0;
    end
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      mx = int'(bus.drawX);
      my = int'(bus.drawY);
      mb = (bus.vde && my >= GROUND_Y && my < GROUND_Y + GROUND_H) ? 1 : 0;
      ma = (my - GROUND_Y) * GROUND_W + (mx + m_off) % GROUND_W;
      if (mb != 0) m_addr = ma;
      h_band[2] = h_band[1]; h_addr[2] = h_addr[1];
      h_band[1] = h_band[0]; h_addr[1] = h_addr[0];
      h_band[0] = mb;        h_addr[0] = ma;
      if (clear) m_off = 0;
      else if (m_vq == 1 && !vsync && run) m_off = (m_off + int'(speed)) % GROUND_W;
      m_vq = vsync ? 1 : 0;
    end
    #1;
    exp_idx = (h_band[2] != 0) ? int'(rom[h_addr[2]]) : 0;
    check("cyc_offset",    32'(offset),        32'(m_off));
    check("cyc_rom_addr",  32'(bus.rom_addr),  32'(m_addr));
    check("cyc_pix_valid", 32'(bus.pix_valid), 32'(h_band[2]));
    check("cyc_pix_index", 32'(bus.pix_index), 32'(exp_idx));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change only on the falling edge)
  // --------------------------------------------------------------------------
  task automatic beam(input int x, input int y, input bit v);
    bus.drawX = pix_coord_t'(x);
    bus.drawY = pix_coord_t'(y);
    bus.vde   = v;
  endtask

  task automatic tick();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[5] = 4'd9;
    beam(0, 0, 1'b0);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_offset",    32'(offset),        0);
    check("reset_rom_addr",  32'(bus.rom_addr),  0);
    check("reset_pix_valid", 32'(bus.pix_valid), 0);
    check("reset_pix_index", 32'(bus.pix_index), 0);

    // 1: first pixel of the strip
    @(negedge clk);
    reset_n = 1'b1;
    beam(5, 400, 1'b1);
    @(posedge clk); #2;
    check("t1_rom_addr", 32'(bus.rom_addr), 5);
    @(posedge clk); @(posedge clk); #2;
    check("t1_pix_valid", 32'(bus.pix_valid), 1);
    check("t1_pix_index", 32'(bus.pix_index), 9);

    // 2: offset steps once per vsync falling edge
    run = 1'b1; speed = 4'd3;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t2_offset_step", 32'(offset), 32'(3 * k));
    end
    @(negedge clk) vsync = 1'b0;
    repeat (100) @(negedge clk);
    vsync = 1'b1;
    check("t2_long_vsync", 32'(offset), 15);
    speed = 4'd0;
    tick();
    check("t2_speed_zero", 32'(offset), 15);

    // 3: column wrap
    do_clear();
    speed = 4'd10;
    repeat (25) tick();
    check("t3_offset_250", 32'(offset), 250);
    @(negedge clk) beam(10, 401, 1'b1);
    @(negedge clk);
    check("t3_wrap_addr", 32'(bus.rom_addr), 260);

    // 4: clear beats a simultaneous tick
    do_clear();
    repeat (4) tick();
    check("t4_offset_40", 32'(offset), 40);
    @(negedge clk) begin clear = 1'b1; vsync = 1'b0; end
    @(negedge clk) begin
      check("t4_clear_wins", 32'(offset), 0);
      clear = 1'b0; vsync = 1'b1;
    end

    // 5: band edges and blanking inside the band
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) beam(20, 410, 1'b1);
      repeat (3) @(negedge clk);
      case (k)
        0: beam(20, 399, 1'b1);
        1: beam(20, 432, 1'b1);
        default: beam(20, 410, 1'b0);
      endcase
      repeat (3) @(negedge clk);
      check("t5_pix_valid", 32'(bus.pix_valid), 0);
      check("t5_pix_index", 32'(bus.pix_index), 0);
    end

    // 6: asynchronous reset mid-band
    @(negedge clk) beam(100, 420, 1'b1);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.pix_valid), 0);
    check("t6_async_index", 32'(bus.pix_index), 0);
    check("t6_async_addr",  32'(bus.rom_addr),  0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #2 check("t6_edge1_valid", 32'(bus.pix_valid), 0);
    @(posedge clk); #2 check("t6_edge2_valid", 32'(bus.pix_valid), 0);
    @(posedge clk); #2 check("t6_edge3_valid", 32'(bus.pix_valid), 1);

    // Randomized frames, checked cycle by cycle by the model
    for (int f = 0; f < 60; f++) begin
      @(negedge clk) begin
        run   = ($urandom_range(0, 3) != 0);
        speed = 4'($urandom_range(0, 15));
        clear = ($urandom_range(0, 15) == 0);
      end
      repeat ($urandom_range(20, 60)) begin
        @(negedge clk);
        clear = 1'b0;
        beam($urandom_range(0, 639), $urandom_range(395, 437), $urandom_range(0, 3) != 0);
      end
      vsync = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        beam($urandom_range(0, 639), $urandom_range(395, 437), $urandom_range(0, 3) != 0);
      end
      vsync = 1'b1;
      if (f == 30) begin
        #3 reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
